// File: rtl/mf_clkgen_nco.sv
// Multi-channel NCO clock-enable generator: per-channel phase accumulators
// that restart phase-aligned from SYNC and report lock after a settle period.
module mf_clkgen_nco #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned LOCK_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 cfg_wr,
  input  logic [3:0]           cfg_chan,
  input  logic [ACC_WIDTH-1:0] cfg_incr,
  input  logic [ACC_WIDTH-1:0] cfg_phase,
  output logic [CHANNELS-1:0]  ce,
  output logic [CHANNELS-1:0]  clk_out,
  output logic                 locked
);

  localparam int unsigned      CNT_W    = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SYNC, SETTLE, LOCKED} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [ACC_WIDTH-1:0] acc   [CHANNELS];
  logic [ACC_WIDTH-1:0] incr  [CHANNELS];
  logic [ACC_WIDTH-1:0] phase [CHANNELS];
  logic [ACC_WIDTH-1:0] sum   [CHANNELS];
  logic [CHANNELS-1:0]  carry;
  logic [CNT_W-1:0]     cnt;
  logic                 cfg_hit;
  logic                 resync;

  // Writes to channels that do not exist are dropped entirely.
  assign cfg_hit = cfg_wr && ({1'b0, cfg_chan} < 5'(CHANNELS));
  assign resync  = enable && cfg_hit && ((state == SETTLE) || (state == LOCKED));

  // Next-state logic: enable low wins, then resync, then lock.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = SYNC;
        SYNC:    state_nxt = SETTLE;
        SETTLE:  if (resync)               state_nxt = SYNC;
                 else if (cnt == CNT_LAST) state_nxt = LOCKED;
        LOCKED:  if (resync)               state_nxt = SYNC;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Per-channel phase addition with carry-out.
  always_comb begin
    carry = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      {carry[i], sum[i]} = {1'b0, acc[i]} + {1'b0, incr[i]};
    end
  end

  always_comb begin
    clk_out = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      clk_out[i] = acc[i][ACC_WIDTH-1];
    end
  end

  // Outputs follow the next state so that leaving for IDLE clears them at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ce     <= '0;
      locked <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i]   <= '0;
        incr[i]  <= '0;
        phase[i] <= '0;
      end
    end else begin
      state  <= state_nxt;
      locked <= (state_nxt == LOCKED);
      if (state_nxt == IDLE) begin
        cnt <= '0;
        ce  <= '0;
        for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
      end else if (state == SYNC) begin
        cnt <= '0;
        ce  <= '0;
        for (int i = 0; i < CHANNELS; i++) acc[i] <= phase[i];
      end else if (state_nxt == SYNC) begin
        cnt <= '0;
        ce  <= '0;
      end else begin
        if (cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
        ce <= carry;
        for (int i = 0; i < CHANNELS; i++) acc[i] <= sum[i];
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_hit && (cfg_chan == 4'(i))) begin
          incr[i]  <= cfg_incr;
          phase[i] <= cfg_phase;
        end
      end
    end
  end

endmodule
